ex_stage: RTL and testbench

Execute stage of the 16-bit five-stage pipeline, between instruction decode and the memory-access stage. Each `exec` cycle it takes the decoded instruction and its two operands and computes the ALU result, effective address or branch target. It updates the condition flags and evaluates branches, then registers `mem_ir`, `reg_C`, `dw` and `smdr1` for the memory stage. The block holds all state while the CPU is idle.

---
 rtl/ex_stage_pkg.sv | 57 +++++
 rtl/ex_stage_alu16.sv | 92 +++++++++
 rtl/ex_stage.sv | 74 +++++++
 tb/tb_ex_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared constants for the execute stage: CPU run states, the 5-bit opcode map
// and a helper that evaluates a branch condition against a set of flags.
package ex_stage_pkg;

  // CPU run state as seen by the pipeline
  localparam logic IDLE = 1'b0;
  localparam logic EXEC = 1'b1;

  // Opcode field ir[15:11]; LOAD must stay 00010 because the memory stage decodes it
  typedef enum logic [4:0] {
    OP_NOP   = 5'b00000,
    OP_HALT  = 5'b00001,
    OP_LOAD  = 5'b00010,
    OP_STORE = 5'b00011,
    OP_SLL   = 5'b00100,
    OP_SLA   = 5'b00101,
    OP_SRL   = 5'b00110,
    OP_SRA   = 5'b00111,
    OP_ADD   = 5'b01000,
    OP_ADDI  = 5'b01001,
    OP_SUB   = 5'b01010,
    OP_SUBI  = 5'b01011,
    OP_CMP   = 5'b01100,
    OP_AND   = 5'b01101,
    OP_OR    = 5'b01110,
    OP_XOR   = 5'b01111,
    OP_LDIH  = 5'b10000,
    OP_ADDC  = 5'b10001,
    OP_SUBC  = 5'b10010,
    OP_JUMP  = 5'b11000,
    OP_JMPR  = 5'b11001,
    OP_BZ    = 5'b11010,
    OP_BNZ   = 5'b11011,
    OP_BN    = 5'b11100,
    OP_BNN   = 5'b11101,
    OP_BC    = 5'b11110,
    OP_BNC   = 5'b11111
  } opcode_t;

  // Decide whether a jump/branch is taken, given the flags currently held
  function automatic logic branch_taken(input opcode_t op, input logic zf,
                                        input logic nf, input logic cf);
    logic taken;
    case (op)
      OP_JUMP, OP_JMPR: taken = 1'b1;
      OP_BZ:            taken = zf;
      OP_BNZ:           taken = ~zf;
      OP_BN:            taken = nf;
      OP_BNN:           taken = ~nf;
      OP_BC:            taken = cf;
      OP_BNC:           taken = ~cf;
      default:          taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/ex_stage_alu16.sv
// Combinational 16-bit ALU for the execute stage. Produces the result
// (ALU value, effective address or jump/branch target), the new carry/borrow
// and the enables that tell the pipeline which flags this opcode writes.
module alu16
  import ex_stage_pkg::*;
(
  input  opcode_t     op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cf_in,
  output logic [15:0] c,
  output logic        cf_out,
  output logic        cf_we,
  output logic        zn_we
);

  logic [16:0] wide;
  logic [3:0]  shamt;

  assign shamt = b[3:0];

  // Opcode decode: result value plus which flags the opcode is allowed to change
  always_comb begin
    wide   = 17'd0;
    c      = 16'd0;
    cf_out = cf_in;
    cf_we  = 1'b0;
    zn_we  = 1'b0;
    case (op)
      OP_ADD, OP_ADDI: begin
        wide   = {1'b0, a} + {1'b0, b};
        c      = wide[15:0];
        cf_out = wide[16];
        cf_we  = 1'b1;
        zn_we  = 1'b1;
      end
      OP_ADDC: begin
        wide   = {1'b0, a} + {1'b0, b} + {16'd0, cf_in};
        c      = wide[15:0];
        cf_out = wide[16];
        cf_we  = 1'b1;
        zn_we  = 1'b1;
      end
      // Bit 16 of the 17-bit difference is the borrow
      OP_SUB, OP_SUBI, OP_CMP: begin
        wide   = {1'b0, a} - {1'b0, b};
        c      = wide[15:0];
        cf_out = wide[16];
        cf_we  = 1'b1;
        zn_we  = 1'b1;
      end
      OP_SUBC: begin
        wide   = {1'b0, a} - {1'b0, b} - {16'd0, cf_in};
        c      = wide[15:0];
        cf_out = wide[16];
        cf_we  = 1'b1;
        zn_we  = 1'b1;
      end
      OP_AND: begin
        c     = a & b;
        zn_we = 1'b1;
      end
      OP_OR: begin
        c     = a | b;
        zn_we = 1'b1;
      end
      OP_XOR: begin
        c     = a ^ b;
        zn_we = 1'b1;
      end
      OP_SLL, OP_SLA: begin
        c     = a << shamt;
        zn_we = 1'b1;
      end
      OP_SRL: begin
        c     = a >> shamt;
        zn_we = 1'b1;
      end
      OP_SRA: begin
        c     = $signed(a) >>> shamt;
        zn_we = 1'b1;
      end
      // Load-immediate-high: immediate byte lands in the upper half
      OP_LDIH: c = a + {b[7:0], 8'h00};
      OP_LOAD, OP_STORE, OP_JMPR,
      OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC: c = a + b;
      OP_JUMP: c = b;
      default: c = 16'd0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage of the 16-bit pipeline. Runs the ALU on the decoded operands,
// evaluates branches against the flags held from earlier instructions, and
// registers everything the memory stage needs. All state holds while idle.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        state,
  input  logic [15:0] ex_ir,
  input  logic [15:0] reg_A,
  input  logic [15:0] reg_B,
  input  logic [15:0] smdr,
  output logic [15:0] mem_ir,
  output logic [15:0] reg_C,
  output logic        dw,
  output logic [15:0] smdr1,
  output logic        zf,
  output logic        nf,
  output logic        cf,
  output logic        branch_flag
);

  opcode_t     op;
  logic [15:0] alu_c;
  logic        alu_cf;
  logic        cf_we;
  logic        zn_we;
  logic        taken;

  assign op = opcode_t'(ex_ir[15:11]);

  alu16 u_alu (
    .op     (op),
    .a      (reg_A),
    .b      (reg_B),
    .cf_in  (cf),
    .c      (alu_c),
    .cf_out (alu_cf),
    .cf_we  (cf_we),
    .zn_we  (zn_we)
  );

  // Branch decision uses the flags as they stand before this edge
  assign taken = branch_taken(op, zf, nf, cf);

  // Pipeline register towards the memory stage, frozen while the CPU is idle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_ir      <= 16'd0;
      reg_C       <= 16'd0;
      dw          <= 1'b0;
      smdr1       <= 16'd0;
      zf          <= 1'b0;
      nf          <= 1'b0;
      cf          <= 1'b0;
      branch_flag <= 1'b0;
    end else if (state == EXEC) begin
      mem_ir      <= ex_ir;
      reg_C       <= alu_c;
      dw          <= (op == OP_STORE);
      smdr1       <= smdr;
      branch_flag <= taken;
      if (zn_we) begin
        zf <= (alu_c == 16'd0);
        nf <= alu_c[15];
      end
      if (cf_we) begin
        cf <= alu_cf;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: a reference model predicts each
// instruction's outputs when it is driven, the prediction is queued, and a
// monitor compares the queue head with the DUT one edge later.
module tb_ex_stage;
  import ex_stage_pkg::*;

  typedef struct packed {
    logic [15:0] mem_ir;
    logic [15:0] reg_c;
    logic        dw;
    logic [15:0] smdr1;
    logic        zf;
    logic        nf;
    logic        cf;
    logic        br;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        state = 1'b0;
  logic [15:0] ex_ir = 16'd0;
  logic [15:0] reg_A = 16'd0;
  logic [15:0] reg_B = 16'd0;
  logic [15:0] smdr  = 16'd0;
  logic [15:0] mem_ir;
  logic [15:0] reg_C;
  logic        dw;
  logic [15:0] smdr1;
  logic        zf;
  logic        nf;
  logic        cf;
  logic        branch_flag;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t last = '0;
  logic m_zf = 1'b0;
  logic m_nf = 1'b0;
  logic m_cf = 1'b0;

  ex_stage dut (
    .clock       (clock),
    .reset       (reset),
    .state       (state),
    .ex_ir       (ex_ir),
    .reg_A       (reg_A),
    .reg_B       (reg_B),
    .smdr        (smdr),
    .mem_ir      (mem_ir),
    .reg_C       (reg_C),
    .dw          (dw),
    .smdr1       (smdr1),
    .zf          (zf),
    .nf          (nf),
    .cf          (cf),
    .branch_flag (branch_flag)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] mk(input logic [4:0] op);
    return {op, 11'd0};
  endfunction

  // Reference model: integer arithmetic, branches read flags before updating them
  task automatic predict(input logic [15:0] ir, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] sd, output exp_t e);
    logic [4:0]  op;
    logic [15:0] c;
    logic [31:0] w;
    logic        ncf;
    logic        zn;
    logic        br;
    int          t;
    op  = ir[15:11];
    c   = 16'd0;
    ncf = m_cf;
    zn  = 1'b0;
    br  = 1'b0;
    case (op)
      OP_ADD, OP_ADDI: begin t = int'(a) + int'(b); c = t[15:0]; ncf = (t > 65535); zn = 1; end
      OP_ADDC: begin t = int'(a) + int'(b) + int'(m_cf); c = t[15:0]; ncf = (t > 65535); zn = 1; end
      OP_SUB, OP_SUBI, OP_CMP: begin c = a - b; ncf = (int'(a) < int'(b)); zn = 1; end
      OP_SUBC: begin c = a - b - {15'd0, m_cf}; ncf = (int'(a) < int'(b) + int'(m_cf)); zn = 1; end
      OP_AND: begin c = a & b; zn = 1; end
      OP_OR:  begin c = a | b; zn = 1; end
      OP_XOR: begin c = a ^ b; zn = 1; end
      OP_SLL, OP_SLA: begin w = {16'd0, a} << b[3:0]; c = w[15:0]; zn = 1; end
      OP_SRL: begin w = {16'd0, a} >> b[3:0]; c = w[15:0]; zn = 1; end
      OP_SRA: begin w = {{16{a[15]}}, a} >> b[3:0]; c = w[15:0]; zn = 1; end
      OP_LDIH: c = a + {b[7:0], 8'h00};
      OP_LOAD, OP_STORE: c = a + b;
      OP_JUMP: begin c = b; br = 1; end
      OP_JMPR: begin c = a + b; br = 1; end
      OP_BZ:  begin c = a + b; br = m_zf; end
      OP_BNZ: begin c = a + b; br = !m_zf; end
      OP_BN:  begin c = a + b; br = m_nf; end
      OP_BNN: begin c = a + b; br = !m_nf; end
      OP_BC:  begin c = a + b; br = m_cf; end
      OP_BNC: begin c = a + b; br = !m_cf; end
      default: c = 16'd0;
    endcase
    if (zn) begin
      m_zf = (c == 16'd0);
      m_nf = c[15];
      m_cf = ncf;
    end
    e.mem_ir = ir;
    e.reg_c  = c;
    e.dw     = (op == OP_STORE);
    e.smdr1  = sd;
    e.zf     = m_zf;
    e.nf     = m_nf;
    e.cf     = m_cf;
    e.br     = br;
  endtask

  task automatic issue(input logic [15:0] ir, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] sd);
    exp_t e;
    @(negedge clock);
    state = EXEC;
    ex_ir = ir;
    reg_A = a;
    reg_B = b;
    smdr  = sd;
    predict(ir, a, b, sd, e);
    exp_q.push_back(e);
  endtask

  task automatic idle_cycle();
    @(negedge clock);
    state = IDLE;
    ex_ir = 16'($urandom);
    reg_A = 16'($urandom);
    reg_B = 16'($urandom);
    smdr  = 16'($urandom);
  endtask

  // Monitor: after each edge compare against the queued prediction, or the held values
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e    = exp_q.pop_front();
        last = e;
      end else begin
        e = last;
      end
      check("mem_ir", mem_ir, e.mem_ir);
      check("reg_C", reg_C, e.reg_c);
      check("dw", {15'd0, dw}, {15'd0, e.dw});
      check("smdr1", smdr1, e.smdr1);
      check("zf", {15'd0, zf}, {15'd0, e.zf});
      check("nf", {15'd0, nf}, {15'd0, e.nf});
      check("cf", {15'd0, cf}, {15'd0, e.cf});
      check("branch_flag", {15'd0, branch_flag}, {15'd0, e.br});
      $display("txn t=%0t ir=%h C=%h dw=%b z=%b n=%b c=%b br=%b",
               $time, mem_ir, reg_C, dw, zf, nf, cf, branch_flag);
    end
  end

  initial begin
    repeat (2) @(negedge clock);
    check("reset_reg_C", reg_C, 16'd0);
    check("reset_mem_ir", mem_ir, 16'd0);
    reset = 1'b1;

    // ADD overflow to zero
    issue(mk(OP_ADD) | 16'h0123, 16'hFFFF, 16'h0001, 16'h0000);
    @(posedge clock); #2;
    check("add_C", reg_C, 16'h0000);
    check("add_cf", {15'd0, cf}, 16'd1);
    check("add_zf", {15'd0, zf}, 16'd1);

    // SUB with borrow, then ADDC consumes it
    issue(mk(OP_SUB), 16'd3, 16'd5, 16'd0);
    @(posedge clock); #2;
    check("sub_C", reg_C, 16'hFFFE);
    check("sub_nf", {15'd0, nf}, 16'd1);
    issue(mk(OP_ADDC), 16'd1, 16'd1, 16'd0);
    @(posedge clock); #2;
    check("addc_C", reg_C, 16'd3);
    check("addc_cf", {15'd0, cf}, 16'd0);

    // STORE then NOP
    issue(mk(OP_STORE), 16'h0010, 16'd4, 16'hBEEF);
    @(posedge clock); #2;
    check("store_C", reg_C, 16'h0014);
    check("store_dw", {15'd0, dw}, 16'd1);
    check("store_smdr1", smdr1, 16'hBEEF);
    issue(mk(OP_NOP), 16'h1234, 16'h5678, 16'h0000);
    @(posedge clock); #2;
    check("nop_dw", {15'd0, dw}, 16'd0);

    // Shifts right
    issue(mk(OP_SRA), 16'h8000, 16'd4, 16'd0);
    @(posedge clock); #2;
    check("sra_C", reg_C, 16'hF800);
    issue(mk(OP_SRL), 16'h8000, 16'd4, 16'd0);
    @(posedge clock); #2;
    check("srl_C", reg_C, 16'h0800);

    // Compare-and-branch pairs
    issue(mk(OP_CMP), 16'd7, 16'd7, 16'd0);
    issue(mk(OP_BZ), 16'h0100, 16'h0020, 16'd0);
    @(posedge clock); #2;
    check("bz_taken", {15'd0, branch_flag}, 16'd1);
    check("bz_C", reg_C, 16'h0120);
    issue(mk(OP_CMP), 16'd7, 16'd7, 16'd0);
    issue(mk(OP_BNZ), 16'h0100, 16'h0020, 16'd0);
    @(posedge clock); #2;
    check("bnz_taken", {15'd0, branch_flag}, 16'd0);

    // Idle hold for three cycles with changing inputs
    repeat (3) idle_cycle();

    // Asynchronous reset pulse in the middle of the high phase
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    check("arst_reg_C", reg_C, 16'd0);
    check("arst_mem_ir", mem_ir, 16'd0);
    check("arst_smdr1", smdr1, 16'd0);
    check("arst_flags", {12'd0, zf, nf, cf, branch_flag}, 16'd0);
    m_zf = 1'b0;
    m_nf = 1'b0;
    m_cf = 1'b0;
    last = '0;
    #1;
    reset = 1'b1;
    issue(mk(OP_JUMP), 16'h1111, 16'h2222, 16'h0000);
    @(posedge clock); #2;
    check("resume_C", reg_C, 16'h2222);

    // Random instruction stream with occasional idle gaps
    for (int i = 0; i < 80; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 7 == 3) a = 16'hFFFF;
      if (i % 11 == 5) b = a;
      if ($urandom_range(0, 5) == 0) idle_cycle();
      issue({5'($urandom_range(0, 31)), 11'($urandom)}, a, b, 16'($urandom));
    end

    @(negedge clock);
    state = IDLE;
    repeat (2) @(posedge clock);
    #3;
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
